// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t : receive controller states
//   DATA_BITS  : payload bits per frame
//   IDLE_LEVEL : level of the serial line when nothing is being sent
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_LOAD
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer
// Baud down-counter that produces the mid-bit sampling ticks.
//   clk, rst    : clock and asynchronous active-high reset
//   start_half  : load a half bit period (first tick lands mid start bit)
//   start_full  : load a full bit period
//   en          : count while a frame is in progress
//   tick        : high for one cycle when the count reaches zero while enabled
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start_half,
    input  logic start_full,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // Loaded values are one less than the wanted distance because the tick
    // fires on the cycle the counter already reads zero.
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == '0);

    // Reloading on every tick keeps the sampling points an exact multiple
    // of the bit period apart, so they never drift across a frame.
    always_comb begin
        cnt_d = cnt_q;
        if (start_half) begin
            cnt_d = HALF_RELOAD;
        end else if (start_full || tick) begin
            cnt_d = FULL_RELOAD;
        end else if (en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive control unit: synchronizes the RX line, qualifies start bits,
// shifts in 8 data bits LSB-first, checks optional parity and the stop bit,
// and strobes the external RX data buffer.
//   clk, rst        : clock and asynchronous active-high reset
//   serial_in       : raw asynchronous RX line (idles high)
//   even_parity_bit : from the buffer, 1 when packet_data has odd ones
//   packet_data     : receive shift register, feeds the buffer
//   load_buffer     : one-cycle strobe telling the buffer to capture
//   framing_error   : last frame's stop bit was 0
//   parity_error    : last frame's parity bit disagreed with even_parity_bit
//   busy            : controller is inside a frame
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 even_parity_bit,
    output logic [DATA_BITS-1:0] packet_data,
    output logic                 load_buffer,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int               BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam bit               PAR_ON   = (PARITY_EN != 0);

    logic [1:0] sync_q;
    logic       rx_s;
    logic       rx_q;
    logic       start_edge;

    rx_state_t            state_q,         state_d;
    logic [DATA_BITS-1:0] packet_data_q,   packet_data_d;
    logic [BIT_W-1:0]     bit_cnt_q,       bit_cnt_d;
    logic                 par_bad_q,       par_bad_d;
    logic                 framing_error_q, framing_error_d;
    logic                 parity_error_q,  parity_error_d;
    logic                 load_buffer_q,   load_buffer_d;
    logic                 busy_q,          busy_d;

    logic start_half;
    logic start_full;
    logic timer_en;
    logic tick;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    // Resetting to the idle level keeps reset release from looking like a
    // start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{IDLE_LEVEL}};
            rx_q   <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[0], serial_in};
            rx_q   <= sync_q[1];
        end
    end

    assign rx_s       = sync_q[1];
    assign start_edge = (rx_q == IDLE_LEVEL) && (rx_s != IDLE_LEVEL);

    assign timer_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .start_half (start_half),
        .start_full (start_full),
        .en         (timer_en),
        .tick       (tick)
    );

    // Next-state logic. Every bit decision waits for a timer tick, so line
    // activity between ticks has no effect. Error flags only move at an
    // accepted start, at the stop sample, or at LOAD, keeping them stable
    // between frames.
    always_comb begin
        state_d         = state_q;
        packet_data_d   = packet_data_q;
        bit_cnt_d       = bit_cnt_q;
        par_bad_d       = par_bad_q;
        framing_error_d = framing_error_q;
        parity_error_d  = parity_error_q;
        load_buffer_d   = 1'b0;
        start_half      = 1'b0;
        start_full      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    start_half = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s == IDLE_LEVEL) begin
                        // Glitch: line already back high at mid start bit.
                        state_d = ST_IDLE;
                    end else begin
                        framing_error_d = 1'b0;
                        parity_error_d  = 1'b0;
                        par_bad_d       = 1'b0;
                        bit_cnt_d       = '0;
                        start_full      = 1'b1;
                        state_d         = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    packet_data_d = {rx_s, packet_data_q[DATA_BITS-1:1]};
                    bit_cnt_d     = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PAR_ON ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_bad_d = (rx_s != even_parity_bit);
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_s != IDLE_LEVEL) begin
                        framing_error_d = 1'b1;
                        state_d         = ST_IDLE;
                    end else begin
                        load_buffer_d = 1'b1;
                        state_d       = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                // Data is handed over even when parity was bad.
                parity_error_d = par_bad_q;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM and its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            packet_data_q   <= '1;
            bit_cnt_q       <= '0;
            par_bad_q       <= 1'b0;
            framing_error_q <= 1'b0;
            parity_error_q  <= 1'b0;
            load_buffer_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            packet_data_q   <= packet_data_d;
            bit_cnt_q       <= bit_cnt_d;
            par_bad_q       <= par_bad_d;
            framing_error_q <= framing_error_d;
            parity_error_q  <= parity_error_d;
            load_buffer_q   <= load_buffer_d;
            busy_q          <= busy_d;
        end
    end

    assign packet_data   = packet_data_q;
    assign load_buffer   = load_buffer_q;
    assign framing_error = framing_error_q;
    assign parity_error  = parity_error_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl. Two instances run side by side:
// dut_a with 10 clocks/bit and parity, dut_b with 4 clocks/bit and no parity.
// Each instance's buffer is modelled by a reduction XOR on packet_data.
module tb_uart_rx_ctrl;

    localparam int CA = 10;
    localparam int CB = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       serial_a = 1'b1;
    logic       serial_b = 1'b1;
    logic [7:0] pd_a, pd_b;
    logic       lb_a, lb_b, fe_a, fe_b, pe_a, pe_b, busy_a, busy_b;
    logic       epb_a, epb_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         ld_cyc_a[$];
    logic [7:0] ld_data_a[$];
    int         ld_cyc_b[$];
    logic [7:0] ld_data_b[$];

    assign epb_a = ^pd_a;
    assign epb_b = ^pd_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle the load strobe is seen high, with the data present.
    always @(negedge clk) begin
        if (lb_a) begin
            ld_cyc_a.push_back(cyc);
            ld_data_a.push_back(pd_a);
        end
        if (lb_b) begin
            ld_cyc_b.push_back(cyc);
            ld_data_b.push_back(pd_b);
        end
    end

    uart_rx_ctrl #(.CLKS_PER_BIT(CA), .PARITY_EN(1)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .serial_in       (serial_a),
        .even_parity_bit (epb_a),
        .packet_data     (pd_a),
        .load_buffer     (lb_a),
        .framing_error   (fe_a),
        .parity_error    (pe_a),
        .busy            (busy_a)
    );

    uart_rx_ctrl #(.CLKS_PER_BIT(CB), .PARITY_EN(0)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .serial_in       (serial_b),
        .even_parity_bit (epb_b),
        .packet_data     (pd_b),
        .load_buffer     (lb_b),
        .framing_error   (fe_b),
        .parity_error    (pe_b),
        .busy            (busy_b)
    );

    // Reference timing: line drops at the negedge where cyc==n0, the start
    // edge is registered 3 clocks later, sampling starts half a bit in, and
    // the strobe is seen in the cycle following the stop sample.
    function automatic int exp_load(input int n0, input int c, input bit pe);
        return n0 + 3 + c / 2 + (pe ? 10 : 9) * c;
    endfunction

    task automatic drive_line(input int sel, input logic v);
        if (sel == 0) serial_a = v;
        else          serial_b = v;
    endtask

    // Must be called at a negedge; sends start, data LSB first (up to
    // max_bits of it), then parity (dut_a only) and stop.
    task automatic send_frame(input int sel, input logic [7:0] data,
                              input logic par, input logic stop,
                              input int max_bits, output int n0);
        int c;
        c  = (sel == 0) ? CA : CB;
        n0 = cyc;
        drive_line(sel, 1'b0);
        repeat (c) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i >= max_bits) return;
            drive_line(sel, data[i]);
            repeat (c) @(negedge clk);
        end
        if (sel == 0) begin
            drive_line(sel, par);
            repeat (c) @(negedge clk);
        end
        drive_line(sel, stop);
        repeat (c) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (pd_a !== 8'hFF) begin failures++; $display("[TB] FAIL reset_pd_a got=%h exp=ff", pd_a); end
        checks++; if (pd_b !== 8'hFF) begin failures++; $display("[TB] FAIL reset_pd_b got=%h exp=ff", pd_b); end
        checks++; if (lb_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_lb got=%b exp=0", lb_a); end
        checks++; if ({fe_a, pe_a} !== 2'b00) begin failures++; $display("[TB] FAIL reset_err got=%b exp=00", {fe_a, pe_a}); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_a); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_clean_frame();
        int n0;
        ld_cyc_a.delete(); ld_data_a.delete();
        send_frame(0, 8'hA5, 1'b0, 1'b1, 8, n0);
        repeat (3) @(negedge clk);
        checks++;
        if (ld_cyc_a.size() !== 1) begin
            failures++; $display("[TB] FAIL clean_loads got=%0d exp=1", ld_cyc_a.size());
        end else begin
            checks++; if (ld_cyc_a[0] !== exp_load(n0, CA, 1'b1)) begin failures++; $display("[TB] FAIL clean_time got=%0d exp=%0d", ld_cyc_a[0], exp_load(n0, CA, 1'b1)); end
            checks++; if (ld_data_a[0] !== 8'hA5) begin failures++; $display("[TB] FAIL clean_data got=%h exp=a5", ld_data_a[0]); end
        end
        checks++; if ({fe_a, pe_a} !== 2'b00) begin failures++; $display("[TB] FAIL clean_err got=%b exp=00", {fe_a, pe_a}); end
    endtask

    task automatic test_false_start();
        int n0;
        logic [7:0] pd_before;
        logic [1:0] err_before;
        ld_cyc_a.delete(); ld_data_a.delete();
        pd_before  = pd_a;
        err_before = {fe_a, pe_a};
        n0 = cyc;
        serial_a = 1'b0;
        repeat (3) @(negedge clk);
        serial_a = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin failures++; $display("[TB] FAIL false_busy_high cyc=%0d got=%b exp=1", cyc - n0, busy_a); end
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL false_busy_low cyc=%0d got=%b exp=0", cyc - n0, busy_a); end
        repeat (20) @(negedge clk);
        checks++; if (ld_cyc_a.size() !== 0) begin failures++; $display("[TB] FAIL false_loads got=%0d exp=0", ld_cyc_a.size()); end
        checks++; if (pd_a !== pd_before) begin failures++; $display("[TB] FAIL false_pd got=%h exp=%h", pd_a, pd_before); end
        checks++; if ({fe_a, pe_a} !== err_before) begin failures++; $display("[TB] FAIL false_err got=%b exp=%b", {fe_a, pe_a}, err_before); end
    endtask

    task automatic test_parity_error();
        int n0;
        ld_cyc_a.delete(); ld_data_a.delete();
        send_frame(0, 8'h3C, 1'b1, 1'b1, 8, n0);
        repeat (3) @(negedge clk);
        checks++;
        if (ld_data_a.size() !== 1) begin
            failures++; $display("[TB] FAIL par_loads got=%0d exp=1", ld_data_a.size());
        end else begin
            checks++; if (ld_data_a[0] !== 8'h3C) begin failures++; $display("[TB] FAIL par_data got=%h exp=3c", ld_data_a[0]); end
        end
        checks++; if (pe_a !== 1'b1) begin failures++; $display("[TB] FAIL par_flag got=%b exp=1", pe_a); end
        checks++; if (fe_a !== 1'b0) begin failures++; $display("[TB] FAIL par_fe got=%b exp=0", fe_a); end
        // Next good frame: flag must hold until the start sample, then clear.
        fork
            send_frame(0, 8'h96, 1'b0, 1'b1, 8, n0);
            begin
                repeat (7) @(negedge clk);
                checks++; if (pe_a !== 1'b1) begin failures++; $display("[TB] FAIL par_hold got=%b exp=1", pe_a); end
                @(negedge clk);
                checks++; if (pe_a !== 1'b0) begin failures++; $display("[TB] FAIL par_clear got=%b exp=0", pe_a); end
            end
        join
        repeat (3) @(negedge clk);
        checks++; if (pe_a !== 1'b0) begin failures++; $display("[TB] FAIL par_after got=%b exp=0", pe_a); end
    endtask

    task automatic test_framing_error();
        int n0;
        int busy_cycles;
        logic [7:0] d;
        ld_cyc_a.delete(); ld_data_a.delete();
        send_frame(0, 8'h0F, 1'b0, 1'b0, 8, n0);
        repeat (3) @(negedge clk);
        checks++; if (fe_a !== 1'b1) begin failures++; $display("[TB] FAIL frm_flag got=%b exp=1", fe_a); end
        checks++; if (ld_cyc_a.size() !== 0) begin failures++; $display("[TB] FAIL frm_loads got=%0d exp=0", ld_cyc_a.size()); end
        busy_cycles = 0;
        for (int i = 0; i < 4 * CA; i++) begin
            @(negedge clk);
            if (busy_a) busy_cycles++;
        end
        checks++; if (busy_cycles !== 0) begin failures++; $display("[TB] FAIL frm_restart busy_cycles=%0d exp=0", busy_cycles); end
        serial_a = 1'b1;
        repeat (5) @(negedge clk);
        d = 8'($urandom);
        send_frame(0, d, ^d, 1'b1, 8, n0);
        repeat (3) @(negedge clk);
        checks++;
        if (ld_data_a.size() !== 1) begin
            failures++; $display("[TB] FAIL frm_recover_loads got=%0d exp=1", ld_data_a.size());
        end else begin
            checks++; if (ld_data_a[0] !== d) begin failures++; $display("[TB] FAIL frm_recover_data got=%h exp=%h", ld_data_a[0], d); end
        end
        checks++; if (fe_a !== 1'b0) begin failures++; $display("[TB] FAIL frm_recover_flag got=%b exp=0", fe_a); end
    endtask

    task automatic test_reset_midframe();
        int n0;
        ld_cyc_b.delete(); ld_data_b.delete();
        send_frame(1, 8'($urandom), 1'b0, 1'b1, 5, n0);
        checks++; if (busy_b !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_before got=%b exp=1", busy_b); end
        #1 rst = 1'b1;
        #1;
        checks++; if (pd_b !== 8'hFF) begin failures++; $display("[TB] FAIL rstmid_pd got=%h exp=ff", pd_b); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy_b); end
        checks++; if ({lb_b, fe_b, pe_b} !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_flags got=%b exp=000", {lb_b, fe_b, pe_b}); end
        serial_b = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (ld_cyc_b.size() !== 0) begin failures++; $display("[TB] FAIL rstmid_loads got=%0d exp=0", ld_cyc_b.size()); end
        send_frame(1, 8'h81, 1'b0, 1'b1, 8, n0);
        repeat (3) @(negedge clk);
        checks++;
        if (ld_cyc_b.size() !== 1) begin
            failures++; $display("[TB] FAIL rstmid_next_loads got=%0d exp=1", ld_cyc_b.size());
        end else begin
            checks++; if (ld_data_b[0] !== 8'h81) begin failures++; $display("[TB] FAIL rstmid_next_data got=%h exp=81", ld_data_b[0]); end
            checks++; if (ld_cyc_b[0] !== exp_load(n0, CB, 1'b0)) begin failures++; $display("[TB] FAIL rstmid_next_time got=%0d exp=%0d", ld_cyc_b[0], exp_load(n0, CB, 1'b0)); end
        end
    endtask

    task automatic test_back_to_back();
        int n0, n1;
        ld_cyc_a.delete(); ld_data_a.delete();
        send_frame(0, 8'h55, 1'b0, 1'b1, 8, n0);
        send_frame(0, 8'hAA, 1'b0, 1'b1, 8, n1);
        repeat (3) @(negedge clk);
        checks++;
        if (ld_cyc_a.size() !== 2) begin
            failures++; $display("[TB] FAIL b2b_loads got=%0d exp=2", ld_cyc_a.size());
        end else begin
            checks++; if (ld_data_a[0] !== 8'h55) begin failures++; $display("[TB] FAIL b2b_data0 got=%h exp=55", ld_data_a[0]); end
            checks++; if (ld_data_a[1] !== 8'hAA) begin failures++; $display("[TB] FAIL b2b_data1 got=%h exp=aa", ld_data_a[1]); end
            checks++; if (ld_cyc_a[0] !== exp_load(n0, CA, 1'b1)) begin failures++; $display("[TB] FAIL b2b_time0 got=%0d exp=%0d", ld_cyc_a[0], exp_load(n0, CA, 1'b1)); end
            checks++; if (ld_cyc_a[1] - ld_cyc_a[0] !== 11 * CA) begin failures++; $display("[TB] FAIL b2b_gap got=%0d exp=%0d", ld_cyc_a[1] - ld_cyc_a[0], 11 * CA); end
        end
    endtask

    task automatic test_random_frames();
        int n0;
        logic [7:0] d;
        logic bad;
        for (int k = 0; k < 8; k++) begin
            ld_cyc_a.delete(); ld_data_a.delete();
            d   = 8'($urandom);
            bad = 1'($urandom_range(0, 1));
            send_frame(0, d, (^d) ^ bad, 1'b1, 8, n0);
            repeat (2) @(negedge clk);
            checks++;
            if (ld_cyc_a.size() !== 1) begin
                failures++; $display("[TB] FAIL rand_a_loads k=%0d got=%0d exp=1", k, ld_cyc_a.size());
            end else begin
                checks++; if (ld_data_a[0] !== d) begin failures++; $display("[TB] FAIL rand_a_data k=%0d got=%h exp=%h", k, ld_data_a[0], d); end
                checks++; if (ld_cyc_a[0] !== exp_load(n0, CA, 1'b1)) begin failures++; $display("[TB] FAIL rand_a_time k=%0d got=%0d exp=%0d", k, ld_cyc_a[0], exp_load(n0, CA, 1'b1)); end
            end
            checks++; if (pe_a !== bad) begin failures++; $display("[TB] FAIL rand_a_parity k=%0d got=%b exp=%b", k, pe_a, bad); end
        end
        for (int k = 0; k < 6; k++) begin
            ld_cyc_b.delete(); ld_data_b.delete();
            d = 8'($urandom);
            send_frame(1, d, 1'b0, 1'b1, 8, n0);
            repeat (2) @(negedge clk);
            checks++;
            if (ld_cyc_b.size() !== 1) begin
                failures++; $display("[TB] FAIL rand_b_loads k=%0d got=%0d exp=1", k, ld_cyc_b.size());
            end else begin
                checks++; if (ld_data_b[0] !== d) begin failures++; $display("[TB] FAIL rand_b_data k=%0d got=%h exp=%h", k, ld_data_b[0], d); end
                checks++; if (ld_cyc_b[0] !== exp_load(n0, CB, 1'b0)) begin failures++; $display("[TB] FAIL rand_b_time k=%0d got=%0d exp=%0d", k, ld_cyc_b[0], exp_load(n0, CB, 1'b0)); end
            end
            checks++; if ({fe_b, pe_b} !== 2'b00) begin failures++; $display("[TB] FAIL rand_b_err k=%0d got=%b exp=00", k, {fe_b, pe_b}); end
        end
    endtask

    initial begin
        $display("[TB] starting uart_rx_ctrl bench");
        test_reset();
        test_clean_frame();
        test_false_start();
        test_parity_error();
        test_framing_error();
        test_reset_midframe();
        test_back_to_back();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
